aes_round_sched: RTL and testbench

AES_ROUND_SCHED -- requirements
Module: aes_round_sched

---
 rtl/aes_ctrl_pkg.sv | 17 +
 rtl/aes_round_sched.sv | 82 ++++++++
 tb/tb_aes_round_sched.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the AES control slice: FSM encoding, default round
// count, round-counter width and the AES-128 key width.
package aes_ctrl_pkg;

  localparam int unsigned NR_DEFAULT = 10;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned KEY_W      = 128;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    INIT  = 3'd2,
    ROUND = 3'd3,
    HOLD  = 3'd4
  } state_t;

endpackage

// File: rtl/aes_round_sched.sv
// AES round sequencer: loads the key expansion, strobes the initial key add,
// steps NR rounds in lockstep with the expansion, then holds the result.
module aes_round_sched
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned NR = NR_DEFAULT
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [KEY_W-1:0] key_in,
  input  logic             abort,
  output logic [KEY_W-1:0] key_out,
  output logic             ks_sel,
  output logic             dp_init,
  output logic             dp_round,
  output logic [CNT_W-1:0] round_idx,
  output logic             final_round,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam logic [CNT_W-1:0] NR_C = CNT_W'(NR);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      key_out <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && in_valid)
        key_out <= key_in;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    case (state)
      IDLE:  if (in_valid) state_nxt = LOAD;
      LOAD:  state_nxt = INIT;
      INIT: begin
        state_nxt = ROUND;
        cnt_nxt   = CNT_W'(1);
      end
      ROUND: begin
        // A counter outside 1..NR can only come from corruption; bail to IDLE.
        if (cnt == NR_C)
          state_nxt = HOLD;
        else if (cnt > NR_C || cnt == '0)
          state_nxt = IDLE;
        else
          cnt_nxt = cnt + CNT_W'(1);
      end
      HOLD:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort && state != IDLE) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end
  end

  always_comb begin
    in_ready    = (state == IDLE);
    busy        = (state != IDLE);
    ks_sel      = (state == LOAD);
    dp_init     = (state == INIT);
    dp_round    = (state == ROUND);
    round_idx   = (state == ROUND) ? cnt : '0;
    final_round = (state == ROUND) && (cnt == NR_C);
    out_valid   = (state == HOLD);
  end

endmodule

// File: tb/tb_aes_round_sched.sv
// Directed bench for aes_round_sched with a behavioural AES-128 key expansion
// attached to key_out/ks_sel and a scoreboard of accepted blocks.
module tb_aes_round_sched;

  localparam int NR = 10;
  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic         CLK = 1'b0;
  logic         reset, in_valid, abort, out_ready;
  logic [127:0] key_in;
  logic         in_ready, ks_sel, dp_init, dp_round, final_round, out_valid, busy;
  logic [127:0] key_out;
  logic [3:0]   round_idx;

  aes_round_sched #(.NR(NR)) dut (
    .CLK(CLK), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .key_in(key_in), .abort(abort), .key_out(key_out), .ks_sel(ks_sel),
    .dp_init(dp_init), .dp_round(dp_round), .round_idx(round_idx),
    .final_round(final_round), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] inv;
    inv = 8'h00;
    for (int i = 1; i < 256; i++)
      if (gmul(b, 8'(i)) == 8'h01) inv = 8'(i);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] n);
    case (n)
      4'd1: return 8'h01;  4'd2: return 8'h02;  4'd3: return 8'h04;
      4'd4: return 8'h08;  4'd5: return 8'h10;  4'd6: return 8'h20;
      4'd7: return 8'h40;  4'd8: return 8'h80;  4'd9: return 8'h1b;
      4'd10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] ks_next(input logic [127:0] w, input logic [3:0] n);
    logic [31:0] w0, w1, w2, w3, r, t;
    w0 = w[127:96]; w1 = w[95:64]; w2 = w[63:32]; w3 = w[31:0];
    r  = {w3[23:0], w3[31:24]};
    t  = {sbox(r[31:24]), sbox(r[23:16]), sbox(r[15:8]), sbox(r[7:0])} ^ {rcon(n), 24'h0};
    w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] exp_rk(input logic [127:0] key, input int r);
    logic [127:0] k;
    k = key;
    for (int i = 1; i <= r; i++) k = ks_next(k, 4'(i));
    return k;
  endfunction

  // Key expansion: load on ks_sel, otherwise advance one round per cycle.
  logic [127:0] rk;
  logic [3:0]   rnd;
  always @(posedge CLK) begin
    if (ks_sel) begin
      rk  <= key_out;
      rnd <= 4'd1;
    end else begin
      rk  <= ks_next(rk, rnd);
      rnd <= rnd + 4'd1;
    end
  end

  typedef struct { logic [127:0] key; logic [127:0] rk10; } sb_t;
  sb_t sb[$];

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_load = 0;
  bit btb_prev = 1'b0;
  logic [127:0] rk_last;

  localparam logic [10:0] IDLE_V = {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
  localparam logic [10:0] LOAD_V = {1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1};
  localparam logic [10:0] INIT_V = {1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1};
  localparam logic [10:0] HOLD_V = {1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1};

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctrl(input string tag, input logic [10:0] exp);
    chk(tag, 128'({in_ready, ks_sel, dp_init, dp_round, round_idx, final_round, out_valid, busy}),
        128'(exp));
  endtask

  // cut_at: round at which to abort (or reset if cut_rst); NR+1 aborts in HOLD.
  // btb keeps in_valid high with junk key_in while busy, then offers nxt.
  task automatic run_block(input logic [127:0] key, input int cut_at, input bit cut_rst,
                           input int hold_wait, input bit btb, input logic [127:0] nxt);
    sb_t e;
    e.key  = key;
    e.rk10 = (key == FIPS_KEY) ? FIPS_RK10 : exp_rk(key, NR);
    in_valid = 1'b1;
    key_in   = key;
    sb.push_back(e);
    step();
    abort = 1'b0;
    if (btb) key_in = ~key; else in_valid = 1'b0;
    chk_ctrl("load", LOAD_V);
    chk("key_capture", key_out, key);
    if (btb_prev) chk("btb_period", 128'(cyc - last_load), 128'(14));
    last_load = cyc;
    btb_prev  = 1'b0;
    step();
    chk_ctrl("init", INIT_V);
    chk("rkey0", rk, key);
    for (int r = 1; r <= NR; r++) begin
      if (r == NR) out_ready = (hold_wait == 0);
      step();
      chk_ctrl("round", {1'b0, 1'b0, 1'b0, 1'b1, 4'(r), (r == NR), 1'b0, 1'b1});
      chk("rkey", rk, exp_rk(key, r));
      if (btb) chk("key_stable_busy", key_out, key);
      if (r == NR) rk_last = rk;
      if (r == cut_at) begin
        if (cut_rst) reset = 1'b1; else abort = 1'b1;
        step();
        reset = 1'b0;
        abort = 1'b0;
        chk_ctrl(cut_rst ? "reset_idle" : "abort_idle", IDLE_V);
        if (cut_rst) chk("reset_key", key_out, '0);
        void'(sb.pop_front());
        return;
      end
    end
    step();
    chk_ctrl("hold", HOLD_V);
    if (cut_at == NR + 1) begin
      abort = 1'b1;
      out_ready = 1'b1;
      step();
      abort = 1'b0;
      out_ready = 1'b0;
      chk_ctrl("abort_hold_idle", IDLE_V);
      void'(sb.pop_front());
      return;
    end
    for (int i = 0; i < hold_wait; i++) begin
      step();
      chk_ctrl("hold_wait", HOLD_V);
    end
    out_ready = 1'b1;
    if (btb) key_in = nxt;
    if (sb.size() == 0) begin
      n_assert++; n_fail++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk("sb_key", key_out, e.key);
      chk("sb_rk10", rk_last, e.rk10);
    end
    step();
    chk_ctrl("done_idle", IDLE_V);
    if (!btb) out_ready = 1'b0;
    btb_prev = btb;
  endtask

  logic [127:0] k [0:8];

  initial begin
    for (int i = 0; i < 9; i++)
      k[i] = {$urandom, $urandom, $urandom, $urandom};
    reset = 1'b1; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0; key_in = k[0];
    step();
    step();
    chk_ctrl("reset_outputs", IDLE_V);
    chk("reset_key_out", key_out, '0);
    reset = 1'b0;

    abort = 1'b1;
    step();
    chk_ctrl("abort_in_idle", IDLE_V);
    abort = 1'b0;

    run_block(FIPS_KEY, 0, 1'b0, 5, 1'b0, '0);
    abort = 1'b1;                       // together with in_valid: block accepted
    run_block(k[1], 0, 1'b0, 0, 1'b0, '0);
    run_block(k[2], 4, 1'b0, 1, 1'b0, '0);
    run_block(k[3], 0, 1'b0, 1, 1'b0, '0);
    run_block(k[4], 7, 1'b1, 0, 1'b0, '0);
    run_block(k[5], NR + 1, 1'b0, 0, 1'b0, '0);
    run_block(k[6], 0, 1'b0, 0, 1'b1, k[7]);
    run_block(k[7], 0, 1'b0, 0, 1'b1, k[8]);
    run_block(k[8], 0, 1'b0, 0, 1'b0, '0);

    for (int i = 0; i < 3; i++) begin
      step();
      chk_ctrl("final_idle", IDLE_V);
      chk("final_key", key_out, k[8]);
    end
    chk("sb_drained", 128'(sb.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
